// File: rtl/branch_unit.sv
// branch_unit: branch execution stage.
// Resolves the condition, target and link value of one branch/jump per cycle
// and broadcasts the result on the branch CDB one cycle later. When the macro
// BRANCH_BHT_EN is defined, a table of 2-bit saturating counters is trained on
// resolved conditional branches and queried by fetch for direction prediction.
// Without the macro the prediction is static not-taken.
module branch_unit #(
    parameter int DATA_W    = 32,
    parameter int TAG_W     = 4,
    parameter int OP_W      = 6,
    parameter int BHT_IDX_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [OP_W-1:0]   in_op,
    input  logic [DATA_W-1:0] in_reg1,
    input  logic [DATA_W-1:0] in_reg2,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [TAG_W-1:0]  in_dest_tag,
    output logic              cdb_valid,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [DATA_W-1:0] cdb_data,
    output logic              cdb_taken,
    output logic [DATA_W-1:0] cdb_target,
    input  logic [DATA_W-1:0] fetch_pc,
    output logic              fetch_pred_taken
);

    // Decoded opcode values shared with the decode stage.
    localparam logic [OP_W-1:0] OP_JAL  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_JALR = OP_W'(2);
    localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_BNE  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_BLT  = OP_W'(5);
    localparam logic [OP_W-1:0] OP_BGE  = OP_W'(6);
    localparam logic [OP_W-1:0] OP_BLTU = OP_W'(7);
    localparam logic [OP_W-1:0] OP_BGEU = OP_W'(8);

    logic [DATA_W-1:0] pc_plus4_s;
    logic [DATA_W-1:0] pc_plus_imm_s;
    logic [DATA_W-1:0] jalr_sum_s;
    logic              res_taken_s;
    logic              res_cond_s;
    logic [DATA_W-1:0] res_target_s;
    logic [DATA_W-1:0] res_data_s;
    logic              accept_s;
    logic              train_s;

    logic              cdb_valid_d,  cdb_valid_q;
    logic [TAG_W-1:0]  cdb_tag_d,    cdb_tag_q;
    logic [DATA_W-1:0] cdb_data_d,   cdb_data_q;
    logic              cdb_taken_d,  cdb_taken_q;
    logic [DATA_W-1:0] cdb_target_d, cdb_target_q;

    // fetch_pc is only partly used (or unused) depending on the build.
    logic              unused_fetch_s;
    assign unused_fetch_s = ^fetch_pc;

    assign pc_plus4_s    = in_pc + DATA_W'(4);
    assign pc_plus_imm_s = in_pc + in_imm;
    assign jalr_sum_s    = in_reg1 + in_imm;

    // An instruction is consumed only when enabled and not being flushed.
    assign accept_s = rdy & ~clear & in_valid;
    assign train_s  = accept_s & res_cond_s;

    // Resolve direction, target and link value of the incoming instruction.
    always_comb begin
        res_taken_s  = 1'b0;
        res_cond_s   = 1'b0;
        res_target_s = pc_plus4_s;
        res_data_s   = '0;
        case (in_op)
            OP_JAL: begin
                res_taken_s = 1'b1;
                res_data_s  = pc_plus4_s;
            end
            OP_JALR: begin
                res_taken_s = 1'b1;
                res_data_s  = pc_plus4_s;
            end
            OP_BEQ: begin
                res_cond_s  = 1'b1;
                res_taken_s = (in_reg1 == in_reg2);
            end
            OP_BNE: begin
                res_cond_s  = 1'b1;
                res_taken_s = (in_reg1 != in_reg2);
            end
            OP_BLT: begin
                res_cond_s  = 1'b1;
                res_taken_s = ($signed(in_reg1) < $signed(in_reg2));
            end
            OP_BGE: begin
                res_cond_s  = 1'b1;
                res_taken_s = ($signed(in_reg1) >= $signed(in_reg2));
            end
            OP_BLTU: begin
                res_cond_s  = 1'b1;
                res_taken_s = (in_reg1 < in_reg2);
            end
            OP_BGEU: begin
                res_cond_s  = 1'b1;
                res_taken_s = (in_reg1 >= in_reg2);
            end
            default: begin
                res_taken_s = 1'b0;
            end
        endcase
        if (in_op == OP_JALR) begin
            res_target_s = {jalr_sum_s[DATA_W-1:1], 1'b0};
        end else if (res_taken_s) begin
            res_target_s = pc_plus_imm_s;
        end else begin
            res_target_s = pc_plus4_s;
        end
    end

    // Next CDB state: flush wins, then freeze on !rdy, else load or retire.
    always_comb begin
        cdb_valid_d  = cdb_valid_q;
        cdb_tag_d    = cdb_tag_q;
        cdb_data_d   = cdb_data_q;
        cdb_taken_d  = cdb_taken_q;
        cdb_target_d = cdb_target_q;
        if (clear) begin
            cdb_valid_d  = 1'b0;
            cdb_tag_d    = '0;
            cdb_data_d   = '0;
            cdb_taken_d  = 1'b0;
            cdb_target_d = '0;
        end else if (rdy) begin
            if (in_valid) begin
                cdb_valid_d  = 1'b1;
                cdb_tag_d    = in_dest_tag;
                cdb_data_d   = res_data_s;
                cdb_taken_d  = res_taken_s;
                cdb_target_d = res_target_s;
            end else begin
                cdb_valid_d  = 1'b0;
            end
        end else begin
            cdb_valid_d  = cdb_valid_q;
        end
    end

    // CDB output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cdb_valid_q  <= 1'b0;
            cdb_tag_q    <= '0;
            cdb_data_q   <= '0;
            cdb_taken_q  <= 1'b0;
            cdb_target_q <= '0;
        end else begin
            cdb_valid_q  <= cdb_valid_d;
            cdb_tag_q    <= cdb_tag_d;
            cdb_data_q   <= cdb_data_d;
            cdb_taken_q  <= cdb_taken_d;
            cdb_target_q <= cdb_target_d;
        end
    end

    assign cdb_valid  = cdb_valid_q;
    assign cdb_tag    = cdb_tag_q;
    assign cdb_data   = cdb_data_q;
    assign cdb_taken  = cdb_taken_q;
    assign cdb_target = cdb_target_q;

`ifdef BRANCH_BHT_EN
    localparam int BHT_ENTRIES = 1 << BHT_IDX_W;

    // Saturating 2-bit counter step towards the resolved direction.
    function automatic logic [1:0] sat_step(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        if (taken) begin
            nxt = (ctr == 2'd3) ? 2'd3 : ctr + 2'd1;
        end else begin
            nxt = (ctr == 2'd0) ? 2'd0 : ctr - 2'd1;
        end
        return nxt;
    endfunction

    logic [1:0]           bht_d [BHT_ENTRIES];
    logic [1:0]           bht_q [BHT_ENTRIES];
    logic [BHT_IDX_W-1:0] upd_idx_s;
    logic [BHT_IDX_W-1:0] qry_idx_s;

    assign upd_idx_s = in_pc[BHT_IDX_W+1:2];
    assign qry_idx_s = fetch_pc[BHT_IDX_W+1:2];

    // Counter table next state: only the entry of a trained branch moves.
    always_comb begin
        for (int i = 0; i < BHT_ENTRIES; i++) begin
            bht_d[i] = bht_q[i];
        end
        if (train_s) begin
            bht_d[upd_idx_s] = sat_step(bht_q[upd_idx_s], res_taken_s);
        end else begin
            bht_d[upd_idx_s] = bht_q[upd_idx_s];
        end
    end

    // Counter table registers; reset to weakly not-taken.
    always_ff @(posedge clk) begin
        for (int i = 0; i < BHT_ENTRIES; i++) begin
            if (rst) begin
                bht_q[i] <= 2'd1;
            end else begin
                bht_q[i] <= bht_d[i];
            end
        end
    end

    // Prediction reads the pre-update counter.
    assign fetch_pred_taken = bht_q[qry_idx_s][1];
`else
    logic unused_train_s;
    assign unused_train_s   = train_s;
    assign fetch_pred_taken = 1'b0;
`endif

endmodule

// File: tb/tb_branch_unit.sv
// Self-checking bench for branch_unit: directed vector table, hand-written
// multi-cycle sequences and randomized traffic against a behavioural model.
module tb_branch_unit;

    localparam logic [5:0] JAL  = 6'd1;
    localparam logic [5:0] JALR = 6'd2;
    localparam logic [5:0] BEQ  = 6'd3;
    localparam logic [5:0] BNE  = 6'd4;
    localparam logic [5:0] BLT  = 6'd5;
    localparam logic [5:0] BGE  = 6'd6;
    localparam logic [5:0] BLTU = 6'd7;
    localparam logic [5:0] BGEU = 6'd8;

    logic        clk = 1'b0;
    logic        rst, rdy, clear, in_valid;
    logic [5:0]  in_op;
    logic [31:0] in_reg1, in_reg2, in_imm, in_pc, fetch_pc;
    logic [3:0]  in_dest_tag;
    logic        cdb_valid, cdb_taken, fetch_pred_taken;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_data, cdb_target;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    logic        e_valid, e_taken, e_def;
    logic [3:0]  e_tag;
    logic [31:0] e_data, e_target;
    int          ctr [64];

    branch_unit dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear(clear), .in_valid(in_valid),
        .in_op(in_op), .in_reg1(in_reg1), .in_reg2(in_reg2), .in_imm(in_imm),
        .in_pc(in_pc), .in_dest_tag(in_dest_tag), .cdb_valid(cdb_valid),
        .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_taken(cdb_taken),
        .cdb_target(cdb_target), .fetch_pc(fetch_pc),
        .fetch_pred_taken(fetch_pred_taken)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] r1, r2, imm, pc;
        logic [3:0]  tag;
        logic        exp_taken;
        logic [31:0] exp_target, exp_data;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Architectural meaning of each opcode, written directly from the rules.
    task automatic model_resolve(input logic [5:0] op, input logic [31:0] r1, r2, imm, pc,
                                 output logic tk, output logic [31:0] tgt, dat,
                                 output logic cond);
        tk = 1'b0; cond = 1'b0; dat = 32'd0;
        case (op)
            JAL:  begin tk = 1'b1; dat = pc + 32'd4; end
            JALR: begin tk = 1'b1; dat = pc + 32'd4; end
            BEQ:  begin cond = 1'b1; tk = (r1 == r2); end
            BNE:  begin cond = 1'b1; tk = (r1 != r2); end
            BLT:  begin cond = 1'b1; tk = ($signed(r1) <  $signed(r2)); end
            BGE:  begin cond = 1'b1; tk = ($signed(r1) >= $signed(r2)); end
            BLTU: begin cond = 1'b1; tk = (r1 <  r2); end
            BGEU: begin cond = 1'b1; tk = (r1 >= r2); end
            default: tk = 1'b0;
        endcase
        if (op == JALR)  tgt = (r1 + imm) & 32'hFFFF_FFFE;
        else if (tk)     tgt = pc + imm;
        else             tgt = pc + 32'd4;
    endtask

    function automatic logic model_pred(input logic [31:0] pc);
`ifdef BRANCH_BHT_EN
        return ctr[(pc >> 2) % 64] >= 2;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic bht_only(input logic b);
`ifdef BRANCH_BHT_EN
        return b;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        e_valid = 1'b0; e_tag = 4'd0; e_data = 32'd0; e_taken = 1'b0;
        e_target = 32'd0; e_def = 1'b1;
        for (int i = 0; i < 64; i++) ctr[i] = 1;
    endtask

    // One clock: check prediction, clock, advance model, check CDB.
    task automatic step();
        logic tk, cond;
        logic [31:0] tgt, dat;
        int idx;
        #1;
        chk("pred", {31'd0, fetch_pred_taken}, {31'd0, model_pred(fetch_pc)});
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (clear) begin
            e_valid = 1'b0; e_tag = 4'd0; e_data = 32'd0; e_taken = 1'b0;
            e_target = 32'd0; e_def = 1'b1;
        end else if (rdy) begin
            if (in_valid) begin
                model_resolve(in_op, in_reg1, in_reg2, in_imm, in_pc, tk, tgt, dat, cond);
                e_valid = 1'b1; e_tag = in_dest_tag; e_taken = tk;
                e_target = tgt; e_data = dat; e_def = 1'b1;
                if (cond) begin
                    idx = int'((in_pc >> 2) % 64);
                    if (tk) ctr[idx] = (ctr[idx] == 3) ? 3 : ctr[idx] + 1;
                    else    ctr[idx] = (ctr[idx] == 0) ? 0 : ctr[idx] - 1;
                end
            end else begin
                e_valid = 1'b0; e_def = 1'b0;
            end
        end
        @(negedge clk);
        chk("cdb_valid", {31'd0, cdb_valid}, {31'd0, e_valid});
        if (e_def) begin
            chk("cdb_tag", {28'd0, cdb_tag}, {28'd0, e_tag});
            chk("cdb_data", cdb_data, e_data);
            chk("cdb_taken", {31'd0, cdb_taken}, {31'd0, e_taken});
            chk("cdb_target", cdb_target, e_target);
        end
    endtask

    task automatic idle();
        rst = 1'b0; clear = 1'b0; rdy = 1'b1; in_valid = 1'b0;
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] r1, r2, imm, pc,
                         input logic [3:0] tag);
        in_valid = 1'b1; in_op = op; in_reg1 = r1; in_reg2 = r2;
        in_imm = imm; in_pc = pc; in_dest_tag = tag;
    endtask

    task automatic pred_at(input string nm, input logic [31:0] pc, input logic exp);
        fetch_pc = pc;
        #1;
        chk(nm, {31'd0, fetch_pred_taken}, {31'd0, exp});
    endtask

    task automatic do_reset();
        idle(); rst = 1'b1; step(); rst = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{BEQ,  32'd5,          32'd5, 32'h20,       32'h100,      4'd3, 1'b1, 32'h120,  32'h0};
        vecs[1]  = '{BLT,  32'hFFFF_FFFF,  32'd1, 32'h10,       32'h300,      4'd4, 1'b1, 32'h310,  32'h0};
        vecs[2]  = '{BLTU, 32'hFFFF_FFFF,  32'd1, 32'h10,       32'h300,      4'd5, 1'b0, 32'h304,  32'h0};
        vecs[3]  = '{JALR, 32'h1003,       32'd0, 32'h4,        32'h200,      4'd6, 1'b1, 32'h1006, 32'h204};
        vecs[4]  = '{JAL,  32'd0,          32'd0, 32'hFFFF_FFF0, 32'h1000,    4'd7, 1'b1, 32'hFF0,  32'h1004};
        vecs[5]  = '{BNE,  32'd7,          32'd7, 32'h8,        32'h80,       4'd8, 1'b0, 32'h84,   32'h0};
        vecs[6]  = '{BGE,  32'h8000_0000,  32'd0, 32'h40,       32'h500,      4'd9, 1'b0, 32'h504,  32'h0};
        vecs[7]  = '{BGEU, 32'h8000_0000,  32'd0, 32'h40,       32'h500,      4'd10, 1'b1, 32'h540, 32'h0};
        vecs[8]  = '{6'h3F, 32'd1,         32'd1, 32'h40,       32'h600,      4'd11, 1'b0, 32'h604, 32'h0};
        vecs[9]  = '{BEQ,  32'd0,          32'd0, 32'h8,        32'hFFFF_FFFC, 4'd12, 1'b1, 32'h4,  32'h0};
        vecs[10] = '{BGE,  32'd3,          32'd3, 32'hC,        32'h700,      4'd13, 1'b1, 32'h70C, 32'h0};

        idle(); rst = 1'b1; in_op = 6'd0; in_reg1 = 32'd0; in_reg2 = 32'd0;
        in_imm = 32'd0; in_pc = 32'd0; in_dest_tag = 4'd0; fetch_pc = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        rst = 1'b0;

        // Reset state and idle
        chk("rst_valid", {31'd0, cdb_valid}, 32'd0);
        chk("rst_tag", {28'd0, cdb_tag}, 32'd0);
        chk("rst_data", cdb_data, 32'd0);
        chk("rst_taken", {31'd0, cdb_taken}, 32'd0);
        chk("rst_target", cdb_target, 32'd0);
        for (int i = 0; i < 8; i++) pred_at("rst_pred", $urandom, 1'b0);
        step();

        // Directed vector table
        for (int i = 0; i < 11; i++) begin
            idle();
            issue(vecs[i].op, vecs[i].r1, vecs[i].r2, vecs[i].imm, vecs[i].pc, vecs[i].tag);
            step();
            chk("vec_valid", {31'd0, cdb_valid}, 32'd1);
            chk("vec_tag", {28'd0, cdb_tag}, {28'd0, vecs[i].tag});
            chk("vec_taken", {31'd0, cdb_taken}, {31'd0, vecs[i].exp_taken});
            chk("vec_target", cdb_target, vecs[i].exp_target);
            chk("vec_data", cdb_data, vecs[i].exp_data);
            idle();
            step();
            chk("vec_one_cycle", {31'd0, cdb_valid}, 32'd0);
        end

        // JALR does not train
        do_reset();
        issue(JALR, 32'h1003, 32'd0, 32'h4, 32'h200, 4'd1);
        step(); idle();
        pred_at("jalr_pred0", 32'h200, 1'b0);
        issue(JALR, 32'h1003, 32'd0, 32'h4, 32'h200, 4'd1);
        step(); idle(); step();
        pred_at("jalr_pred1", 32'h200, 1'b0);

        // BNE training at pc 0x40: 1->2->3->3 then 2->1
        do_reset();
        for (int i = 0; i < 3; i++) begin
            idle(); issue(BNE, 32'd1, 32'd2, 32'h10, 32'h40, 4'd2);
            step(); idle();
            pred_at("bne_taken_pred", 32'h40, bht_only(1'b1));
        end
        issue(BNE, 32'd2, 32'd2, 32'h10, 32'h40, 4'd2);
        step(); idle();
        pred_at("bne_nt1_pred", 32'h40, bht_only(1'b1));
        issue(BNE, 32'd2, 32'd2, 32'h10, 32'h40, 4'd2);
        step(); idle();
        pred_at("bne_nt2_pred", 32'h40, 1'b0);

        // Same-cycle query and update: pre-update value, new value next cycle
        do_reset();
        fetch_pc = 32'h40;
        issue(BEQ, 32'd9, 32'd9, 32'h10, 32'h40, 4'd3);
        step(); idle();
        pred_at("bypass_next", 32'h40, bht_only(1'b1));

        // Issue with clear: dropped, no training
        do_reset();
        issue(BEQ, 32'd1, 32'd1, 32'h10, 32'h40, 4'd4);
        clear = 1'b1;
        step();
        chk("clear_valid", {31'd0, cdb_valid}, 32'd0);
        chk("clear_target", cdb_target, 32'd0);
        idle();
        pred_at("clear_pred", 32'h40, 1'b0);

        // rdy=0 with issue: outputs held, no new result
        issue(BEQ, 32'd1, 32'd1, 32'h20, 32'h100, 4'd5);
        step();
        rdy = 1'b0;
        issue(BNE, 32'd1, 32'd2, 32'h30, 32'h100, 4'd6);
        step();
        chk("hold_valid", {31'd0, cdb_valid}, 32'd1);
        chk("hold_tag", {28'd0, cdb_tag}, 32'd5);
        chk("hold_target", cdb_target, 32'h120);
        rdy = 1'b1; in_valid = 1'b0;
        step();

        // Clear with rdy=0 still flushes
        issue(JAL, 32'd0, 32'd0, 32'h8, 32'h10, 4'd7);
        step();
        rdy = 1'b0; clear = 1'b1; in_valid = 1'b0;
        step();
        chk("clear_nordy", {31'd0, cdb_valid}, 32'd0);
        idle();

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic [5:0] ops [9];
            ops[0] = JAL; ops[1] = JALR; ops[2] = BEQ; ops[3] = BNE; ops[4] = BLT;
            ops[5] = BGE; ops[6] = BLTU; ops[7] = BGEU; ops[8] = 6'($urandom_range(9, 63));
            rst      = ($urandom_range(0, 199) == 0);
            clear    = ($urandom_range(0, 19) == 0);
            rdy      = ($urandom_range(0, 9) < 8);
            in_valid = ($urandom_range(0, 9) < 7);
            in_op    = ops[$urandom_range(0, 8)];
            in_reg1  = $urandom;
            in_reg2  = ($urandom_range(0, 3) == 0) ? in_reg1 : $urandom;
            in_imm   = $urandom;
            in_pc    = {$urandom_range(0, 3), 26'd0, 4'($urandom_range(0, 7)), 2'($urandom)};
            in_dest_tag = 4'($urandom);
            fetch_pc = {$urandom_range(0, 3), 26'd0, 4'($urandom_range(0, 7)), 2'($urandom)};
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_unit.md
# branch_unit

Branch execution stage, fed directly by the branch reservation station. It receives one operand-complete branch/jump per cycle, resolves the condition, target address and link value, and broadcasts the result on the branch CDB one cycle later. It also maintains a table of 2-bit saturating counters, trained on resolved conditional branches, that fetch queries for direction prediction.

## Interface
- DATA_W, 32, operand/data/address width
- TAG_W, 4, ROB tag width
- OP_W, 6, decoded opcode width
- BHT_IDX_W, 6, log2 of predictor entries (64)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; low freezes all state
- clear  in  1  misprediction flush from ROB
- in_valid  in  1  issue strobe from reservation station
- in_op  in  OP_W  one of JAL, JALR, BEQ, BNE, BLT, BGE, BLTU, BGEU (shared decode defines)
- in_reg1, in_reg2  in  DATA_W  rs1/rs2 values
- in_imm  in  DATA_W  sign-extended immediate
- in_pc  in  DATA_W  instruction address
- in_dest_tag  in  TAG_W  ROB entry of the instruction
- cdb_valid  out  1  result valid
- cdb_tag  out  TAG_W  ROB tag
- cdb_data  out  DATA_W  link value (pc+4) for JAL/JALR, else 0
- cdb_taken  out  1  actual direction (1 for JAL/JALR)
- cdb_target  out  DATA_W  actual next pc
- fetch_pc  in  DATA_W  predictor query address
- fetch_pred_taken  out  1  prediction for fetch_pc (combinational)

## Operation
- Condition: BEQ ==, BNE !=, BLT/BGE signed, BLTU/BGEU unsigned compare of reg1, reg2.
- Target: JAL and conditional taken: pc+imm; JALR: (reg1+imm) with bit 0 cleared; not-taken: pc+4. All adds modulo 2^DATA_W.
- Unknown op with in_valid: cdb_valid=1, taken=0, target=pc+4, data=0.
- Predictor: 2^BHT_IDX_W entries, index = pc[BHT_IDX_W+1:2]. Prediction = counter bit 1. Counter values 0..3, saturating: taken increments (stops at 3), not-taken decrements (stops at 0).
- Training: only conditional branches, in the same edge that registers their result; JAL/JALR never train.
- Outputs are registered; one result per cycle, no backpressure (RS issues at most one per cycle).

## Timing
- Reset: cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_taken=0, cdb_target=0; every counter=1 (weakly not-taken).
- Latency: in_valid sampled at edge N -> cdb_* valid during cycle N+1 only; cdb_valid drops next edge unless new input.
- rdy=0: outputs, counters held; inputs ignored.
- clear=1 (rdy irrelevant): outputs return to reset values next edge; incoming instruction dropped and does not train; counters retained.
- rst has priority over clear; rst mid-stream discards input and reinitialises counters.
- Query and update to same index in the same cycle: fetch_pred_taken reflects pre-update value; new value visible next cycle.
- Back-to-back updates to same index each apply (counter moves once per edge).

## Configuration
- BRANCH_BHT_EN defined: predictor table, training and fetch_pred_taken as above.
- Undefined: no table; fetch_pred_taken tied 0 (static not-taken); resolution/CDB behaviour unchanged.

## Test plan
- Reset then idle -> all cdb_* 0, fetch_pred_taken=0 for any pc.
- BEQ reg1=5 reg2=5 pc=0x100 imm=0x20 tag=3 -> next cycle cdb_valid=1, tag=3, taken=1, target=0x120, data=0; one cycle only.
- BLT reg1=0xFFFFFFFF reg2=1 -> taken; BLTU same operands -> not taken, target=pc+4.
- JALR reg1=0x1003 imm=4 pc=0x200 -> target=0x1006, data=0x204, taken=1; predictor at pc 0x200 unchanged.
- Three taken BNE at pc=0x40 -> counter 1->2->3->3, fetch_pred_taken(0x40)=1 after first; two not-taken -> 1, prediction 0 (with BRANCH_BHT_EN); without macro always 0.
- Issue with clear=1 same edge -> no cdb_valid next cycle, counter untouched; rdy=0 with issue -> no result, outputs held.
